sseg_scan_ctrl: RTL

Time-multiplexed scan controller for an N-digit common-anode seven-segment display. It holds a displayed hex value, walks one digit at a time through a shared hex-to-segment decoder, and drives the active-low anode and cathode buses. New values are loaded through a valid/ready handshake and take effect only at a frame boundary, so a digit scan never shows a mix of old and new values. It sits between the datapath result registers and the board display pins.

---
 rtl/sseg_pkg.sv | 20 ++
 rtl/sseg_scan_ctrl_if.sv | 25 ++
 rtl/sseg_decode.sv | 24 ++
 rtl/sseg_scan_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller: the active-high
// hex glyph table and the cathode bit positions (sseg[7] = dp, [6:0] = g..a).
package sseg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Entry n is the glyph for nibble n, bit SEG_x set = segment lit.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Display-controller bus: load handshake, display data and the pin-side
// anode/cathode outputs. master = producer/board side, slave = controller.
interface sseg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
) ();

  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    blank_in;
  logic                    ready;
  logic [N_DIGITS-1:0]     an;
  logic [7:0]              sseg;

  modport master (
    output load, value, dp_in, blank_in,
    input  ready, an, sseg
  );

  modport slave (
    input  load, value, dp_in, blank_in,
    output ready, an, sseg
  );

endinterface

// File: rtl/sseg_decode.sv
// Combinational nibble to active-high 7-segment glyph lookup.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  logic [6:0] row_s;

  // Table lookup, mapped bit by bit onto the named segment positions.
  always_comb begin
    row_s        = SEG_TABLE[nibble_i];
    seg_o        = 7'h00;
    seg_o[SEG_A] = row_s[SEG_A];
    seg_o[SEG_B] = row_s[SEG_B];
    seg_o[SEG_C] = row_s[SEG_C];
    seg_o[SEG_D] = row_s[SEG_D];
    seg_o[SEG_E] = row_s[SEG_E];
    seg_o[SEG_F] = row_s[SEG_F];
    seg_o[SEG_G] = row_s[SEG_G];
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// New values are held in a pending register and only become active at a
// frame boundary, so one scan never mixes old and new digits.
// Optional build macro SSEG_LZB_EN: leading-zero blanking of the active value.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  sseg_scan_ctrl_if.slave   bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIG_W-1:0]        dig_q, dig_d;
  logic                    pend_full_q, pend_full_d;
  logic [4*N_DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [4*N_DIGITS-1:0]   act_val_q, act_val_d;
  logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;

  logic                    slot_end_s;
  logic                    frame_end_s;
  logic                    accept_s;
  logic [3:0]              nib_s;
  logic [6:0]              seg_s;
  logic                    lzb_dark_s;
  logic                    lit_s;

  // Slot counter and digit index: cnt wraps every REFRESH_DIV, d steps per wrap.
  always_comb begin
    slot_end_s  = (cnt_q == CNT_LAST);
    frame_end_s = slot_end_s && (dig_q == DIG_LAST);
    if (slot_end_s) begin
      cnt_d = '0;
      if (dig_q == DIG_LAST) begin
        dig_d = '0;
      end else begin
        dig_d = dig_q + DIG_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      dig_d = dig_q;
    end
  end

  // Handshake and commit; accept needs an empty pending slot, so a commit and
  // a capture can never collide in the same cycle.
  always_comb begin
    accept_s    = bus.load && !pend_full_q;
    pend_full_d = pend_full_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    if (frame_end_s && pend_full_q) begin
      act_val_d   = pend_val_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end else begin
      pend_full_d = pend_full_q;
    end
    if (accept_s) begin
      pend_val_d  = bus.value;
      pend_dp_d   = bus.dp_in;
      pend_full_d = 1'b1;
    end else begin
      pend_val_d  = pend_val_q;
    end
  end

  assign nib_s = act_val_q[{dig_q, 2'b00} +: 4];

  sseg_decode u_decode (
    .nibble_i (nib_s),
    .seg_o    (seg_s)
  );

`ifdef SSEG_LZB_EN
  logic [N_DIGITS-1:0] lz_s;

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic zrun;
    zrun = 1'b1;
    lz_s = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zrun    = zrun && (act_val_q[4*i +: 4] == 4'h0);
      lz_s[i] = zrun;
    end
    lzb_dark_s = (dig_q != '0) && lz_s[dig_q] && !act_dp_q[dig_q];
  end
`else
  assign lzb_dark_s = 1'b0;
`endif

  // Next anode/cathode pattern for the current slot position.
  always_comb begin
    lit_s  = (cnt_q >= CNT_DEAD) && !bus.blank_in && !lzb_dark_s;
    an_d   = '1;
    sseg_d = 8'hFF;
    for (int i = 0; i < N_DIGITS; i++) begin
      an_d[i] = !(lit_s && (dig_q == DIG_W'(i)));
    end
    if (lit_s) begin
      sseg_d[SEG_DP] = ~act_dp_q[dig_q];
      sseg_d[6:0]    = ~seg_s;
    end else begin
      sseg_d = 8'hFF;
    end
  end

  // State and output registers; reset blanks the display and drops pending data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      dig_q       <= '0;
      pend_full_q <= 1'b0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      an_q        <= '1;
      sseg_q      <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      pend_full_q <= pend_full_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      an_q        <= an_d;
      sseg_q      <= sseg_d;
    end
  end

  assign bus.ready = ~pend_full_q;
  assign bus.an    = an_q;
  assign bus.sseg  = sseg_q;

endmodule
